// File: rtl/exe_mdu.sv
// RV32M multiply/divide unit for the execute stage: single-cycle multiplies,
// 32-step radix-2 restoring divider that stalls the pipeline while it iterates.
module exe_mdu #(
   parameter int                   XLEN        = 32,
   parameter int                   ALUOP_W     = 8,
   parameter logic [ALUOP_W-1:0]   OP_MDU_BASE = 8'h20
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               flush_i,
   input  logic [XLEN-1:0]    op1_i,
   input  logic [XLEN-1:0]    op2_i,
   input  logic [ALUOP_W-1:0] aluOp_i,
   output logic               hit_o,
   output logic [XLEN-1:0]    result_o,
   output logic               stall_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [4:0]        cnt_q, cnt_d;
   logic [XLEN-1:0]   rem_q, rem_d;
   logic [XLEN-1:0]   quot_q, quot_d;
   logic [XLEN-1:0]   dvsr_q, dvsr_d;
   logic              neg_q, neg_d;
   logic              is_rem_q, is_rem_d;

   logic [ALUOP_W-1:0] op_off_s;
   logic               is_mop_s;
   logic [2:0]         fn_s;
   logic               is_div_s;
   logic               div_signed_s;
   logic [2*XLEN-1:0]  mul_a_s, mul_b_s, prod_s;
   logic               div_zero_s, div_ovf_s;
   logic [XLEN-1:0]    a_mag_s, b_mag_s;
   logic [XLEN:0]      shifted_s, diff_s;
   logic [XLEN-1:0]    fin_s, fin_fix_s;
   logic               hit_s, stall_s;
   logic [XLEN-1:0]    res_s;

   // Op decode: an M-op is any code in [BASE, BASE+7]; wrap-around rejects codes below BASE.
   assign op_off_s     = aluOp_i - OP_MDU_BASE;
   assign is_mop_s     = (op_off_s[ALUOP_W-1:3] == '0);
   assign fn_s         = op_off_s[2:0];
   assign is_div_s     = fn_s[2];
   assign div_signed_s = ~fn_s[0];

   // MUL takes the low half, so its operand extension is irrelevant.
   assign mul_a_s = ((fn_s == 3'd1) || (fn_s == 3'd2)) ? {{XLEN{op1_i[XLEN-1]}}, op1_i}
                                                       : {{XLEN{1'b0}}, op1_i};
   assign mul_b_s = (fn_s == 3'd1) ? {{XLEN{op2_i[XLEN-1]}}, op2_i}
                                   : {{XLEN{1'b0}}, op2_i};
   assign prod_s  = mul_a_s * mul_b_s;

   assign div_zero_s = (op2_i == '0);
   assign div_ovf_s  = div_signed_s && (op1_i == {1'b1, {(XLEN-1){1'b0}}}) && (op2_i == '1);
   assign a_mag_s    = (div_signed_s && op1_i[XLEN-1]) ? (~op1_i + 1'b1) : op1_i;
   assign b_mag_s    = (div_signed_s && op2_i[XLEN-1]) ? (~op2_i + 1'b1) : op2_i;

   assign shifted_s = {rem_q, quot_q[XLEN-1]};
   assign diff_s    = shifted_s - {1'b0, dvsr_q};
   assign fin_s     = is_rem_q ? rem_q : quot_q;
   assign fin_fix_s = neg_q ? (~fin_s + 1'b1) : fin_s;

   // Next-state, datapath updates and combinational outputs.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      rem_d    = rem_q;
      quot_d   = quot_q;
      dvsr_d   = dvsr_q;
      neg_d    = neg_q;
      is_rem_d = is_rem_q;
      hit_s    = 1'b0;
      stall_s  = 1'b0;
      res_s    = '0;
      case (state_q)
         S_IDLE: begin
            if (is_mop_s) begin
               hit_s = 1'b1;
               if (!is_div_s) begin
                  res_s = (fn_s[1:0] == 2'd0) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
               end else if (div_zero_s) begin
                  res_s = fn_s[1] ? op1_i : '1;
               end else if (div_ovf_s) begin
                  res_s = fn_s[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
               end else begin
                  stall_s = 1'b1;
                  if (!flush_i) begin
                     state_d  = S_BUSY;
                     cnt_d    = 5'd0;
                     rem_d    = '0;
                     quot_d   = a_mag_s;
                     dvsr_d   = b_mag_s;
                     is_rem_d = fn_s[1];
                     neg_d    = div_signed_s & (fn_s[1] ? op1_i[XLEN-1]
                                                        : (op1_i[XLEN-1] ^ op2_i[XLEN-1]));
                  end else begin
                     state_d = S_IDLE;
                  end
               end
            end else begin
               hit_s = 1'b0;
            end
         end
         S_BUSY: begin
            stall_s = 1'b1;
            hit_s   = is_mop_s;
            if (flush_i) begin
               state_d = S_IDLE;
               cnt_d   = 5'd0;
            end else begin
               if (!diff_s[XLEN]) begin
                  rem_d  = diff_s[XLEN-1:0];
                  quot_d = {quot_q[XLEN-2:0], 1'b1};
               end else begin
                  rem_d  = shifted_s[XLEN-1:0];
                  quot_d = {quot_q[XLEN-2:0], 1'b0};
               end
               cnt_d = cnt_q + 5'd1;
               if (cnt_q == 5'd31) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_BUSY;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            cnt_d   = 5'd0;
            if (!flush_i) begin
               hit_s = 1'b1;
               res_s = fin_fix_s;
            end else begin
               hit_s = 1'b0;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = 5'd0;
         end
      endcase
   end

   // State and divider registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= S_IDLE;
         cnt_q    <= 5'd0;
         rem_q    <= '0;
         quot_q   <= '0;
         dvsr_q   <= '0;
         neg_q    <= 1'b0;
         is_rem_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rem_q    <= rem_d;
         quot_q   <= quot_d;
         dvsr_q   <= dvsr_d;
         neg_q    <= neg_d;
         is_rem_q <= is_rem_d;
      end
   end

   // Outputs are forced quiet for the whole time reset is held.
   assign hit_o    = hit_s & ~rst_i;
   assign stall_o  = stall_s & ~rst_i;
   assign result_o = rst_i ? '0 : res_s;

endmodule

// File: tb/tb_exe_mdu.sv
// Self-checking bench for exe_mdu: scoreboard queue of expected results,
// one task per feature, called in sequence.
module tb_exe_mdu;

   localparam logic [7:0] OP_ADD    = 8'h00;
   localparam logic [7:0] OP_MUL    = 8'h20;
   localparam logic [7:0] OP_MULH   = 8'h21;
   localparam logic [7:0] OP_MULHSU = 8'h22;
   localparam logic [7:0] OP_MULHU  = 8'h23;
   localparam logic [7:0] OP_DIV    = 8'h24;
   localparam logic [7:0] OP_DIVU   = 8'h25;
   localparam logic [7:0] OP_REM    = 8'h26;
   localparam logic [7:0] OP_REMU   = 8'h27;

   logic        clk;
   logic        rst;
   logic        flush;
   logic [31:0] op1, op2;
   logic [7:0]  alu_op;
   logic        hit;
   logic [31:0] result;
   logic        stall;

   int checks   = 0;
   int failures = 0;
   logic [31:0] exp_q[$];

   exe_mdu #(.XLEN(32), .ALUOP_W(8), .OP_MDU_BASE(8'h20)) dut (
      .clk_i    (clk),
      .rst_i    (rst),
      .flush_i  (flush),
      .op1_i    (op1),
      .op2_i    (op2),
      .aluOp_i  (alu_op),
      .hit_o    (hit),
      .result_o (result),
      .stall_o  (stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drives one divide and waits for its result; returns stall count and outputs seen.
   task automatic run_div(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int stalls, output logic [31:0] res, output logic h,
                          output logic s_end);
      bit done;
      alu_op = op; op1 = a; op2 = b;
      stalls = 0;
      done   = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (stall) begin
            stalls++;
            @(posedge clk); #1;
         end else begin
            done = 1'b1;
            break;
         end
      end
      res   = result;
      h     = hit;
      s_end = stall;
      if (!done) stalls = -1;
      @(posedge clk); #1;
      alu_op = OP_ADD;
   endtask

   task automatic test_reset();
      rst = 1'b1; flush = 1'b0;
      alu_op = OP_MUL; op1 = 32'd3; op2 = 32'd5;
      #3;
      checks++;
      if (hit !== 1'b0 || stall !== 1'b0 || result !== 32'd0) begin
         failures++;
         $display("FAIL reset_outputs: hit=%b stall=%b result=%h, required 0/0/0", hit, stall, result);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      alu_op = OP_ADD;
      @(negedge clk);
      checks++;
      if (hit !== 1'b0 || stall !== 1'b0 || result !== 32'd0) begin
         failures++;
         $display("FAIL nonm_op: hit=%b stall=%b result=%h, required 0/0/0", hit, stall, result);
      end
   endtask

   task automatic test_mul();
      logic [7:0]  ops [5] = '{OP_MULH, OP_MULHU, OP_MUL, OP_MULHSU, OP_MUL};
      logic [31:0] as  [5] = '{32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'h12345678};
      logic [31:0] bs  [5] = '{32'h00000003, 32'h00000003, 32'h00000003, 32'h00000003, 32'h00000010};
      logic [31:0] es  [5] = '{32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFA, 32'hFFFFFFFF, 32'h23456780};
      logic [31:0] e;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         alu_op = ops[i]; op1 = as[i]; op2 = bs[i];
         exp_q.push_back(es[i]);
         @(negedge clk);
         e = exp_q.pop_front();
         checks++;
         if (result !== e || stall !== 1'b0 || hit !== 1'b1) begin
            failures++;
            $display("FAIL mul_%0d: result=%h stall=%b hit=%b, required %h/0/1", i, result, stall, hit, e);
         end
      end
      @(posedge clk); #1;
      alu_op = OP_ADD;
   endtask

   task automatic test_fast_path();
      logic [7:0]  ops [4] = '{OP_DIVU, OP_REMU, OP_DIV, OP_REM};
      logic [31:0] as  [4] = '{32'd5, 32'd5, 32'h80000000, 32'h80000000};
      logic [31:0] bs  [4] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
      logic [31:0] es  [4] = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0};
      logic [31:0] e;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         alu_op = ops[i]; op1 = as[i]; op2 = bs[i];
         exp_q.push_back(es[i]);
         @(negedge clk);
         e = exp_q.pop_front();
         checks++;
         if (result !== e || stall !== 1'b0 || hit !== 1'b1) begin
            failures++;
            $display("FAIL fast_%0d: result=%h stall=%b hit=%b, required %h/0/1", i, result, stall, hit, e);
         end
      end
      @(posedge clk); #1;
      alu_op = OP_ADD;
   endtask

   task automatic test_div();
      logic [7:0]  ops [6] = '{OP_DIV, OP_REM, OP_DIVU, OP_DIV, OP_REM, OP_DIVU};
      logic [31:0] as  [6] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd7, 32'd7, 32'hFFFFFFFF};
      logic [31:0] bs  [6] = '{32'd2, 32'd2, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'd1};
      logic [31:0] es  [6] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'hFFFFFFFD, 32'd1, 32'hFFFFFFFF};
      int stalls; logic [31:0] r; logic h, s; logic [31:0] e;
      for (int i = 0; i < 6; i++) begin
         exp_q.push_back(es[i]);
         run_div(ops[i], as[i], bs[i], stalls, r, h, s);
         e = exp_q.pop_front();
         checks++;
         if (r !== e || h !== 1'b1 || s !== 1'b0) begin
            failures++;
            $display("FAIL div_%0d_result: result=%h hit=%b stall=%b, required %h/1/0", i, r, h, s, e);
         end
         checks++;
         if (stalls != 33) begin
            failures++;
            $display("FAIL div_%0d_stalls: stall cycles=%0d, required 33", i, stalls);
         end
      end
      @(negedge clk);
      checks++;
      if (stall !== 1'b0 || hit !== 1'b0) begin
         failures++;
         $display("FAIL done_no_reissue: stall=%b hit=%b, required 0/0", stall, hit);
      end
   endtask

   task automatic test_random_div();
      int stalls; logic [31:0] r; logic h, s; logic [31:0] a, b, e;
      logic [7:0] op;
      for (int i = 0; i < 4; i++) begin
         a  = $urandom;
         b  = $urandom_range(1, 65535);
         op = (i % 2 == 0) ? OP_DIVU : OP_REMU;
         exp_q.push_back((op == OP_DIVU) ? (a / b) : (a % b));
         @(posedge clk); #1;
         run_div(op, a, b, stalls, r, h, s);
         e = exp_q.pop_front();
         checks++;
         if (r !== e || stalls != 33) begin
            failures++;
            $display("FAIL rand_%0d: op=%h a=%h b=%h result=%h stalls=%0d, required %h/33",
                     i, op, a, b, r, stalls, e);
         end
      end
   endtask

   task automatic test_flush();
      @(posedge clk); #1;
      alu_op = OP_DIV; op1 = 32'd1000; op2 = 32'd3;
      repeat (11) @(posedge clk);
      #1;
      flush = 1'b1;
      @(negedge clk);
      checks++;
      if (stall !== 1'b1) begin
         failures++;
         $display("FAIL flush_busy_stall: stall=%b, required 1", stall);
      end
      @(posedge clk); #1;
      flush  = 1'b0;
      alu_op = OP_ADD;
      @(negedge clk);
      checks++;
      if (stall !== 1'b0 || hit !== 1'b0 || result !== 32'd0) begin
         failures++;
         $display("FAIL flush_idle: stall=%b hit=%b result=%h, required 0/0/0", stall, hit, result);
      end
      repeat (40) @(posedge clk);
      @(negedge clk);
      checks++;
      if (stall !== 1'b0 || hit !== 1'b0) begin
         failures++;
         $display("FAIL flush_no_result: stall=%b hit=%b, required 0/0", stall, hit);
      end
   endtask

   task automatic test_async_reset();
      int stalls; logic [31:0] r; logic h, s; logic [31:0] e;
      @(posedge clk); #1;
      alu_op = OP_DIVU; op1 = 32'd500; op2 = 32'd7;
      repeat (6) @(posedge clk);
      @(negedge clk);
      checks++;
      if (stall !== 1'b1) begin
         failures++;
         $display("FAIL pre_reset_busy: stall=%b, required 1", stall);
      end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (stall !== 1'b0 || result !== 32'd0 || hit !== 1'b0) begin
         failures++;
         $display("FAIL async_reset: stall=%b result=%h hit=%b, required 0/0/0", stall, result, hit);
      end
      alu_op = OP_ADD;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (stall !== 1'b0 || hit !== 1'b0) begin
         failures++;
         $display("FAIL post_reset_idle: stall=%b hit=%b, required 0/0", stall, hit);
      end
      @(posedge clk); #1;
      exp_q.push_back(32'd2);
      run_div(OP_REMU, 32'd17, 32'd5, stalls, r, h, s);
      e = exp_q.pop_front();
      checks++;
      if (r !== e || stalls != 33 || h !== 1'b1) begin
         failures++;
         $display("FAIL remu_after_reset: result=%h stalls=%0d hit=%b, required %h/33/1", r, stalls, h, e);
      end
   endtask

   task automatic test_back_to_back();
      int st1, st2; logic [31:0] r1, r2; logic h1, h2, s1, s2; logic [31:0] e;
      @(posedge clk); #1;
      exp_q.push_back(32'd4);
      exp_q.push_back(32'd3);
      run_div(OP_DIVU, 32'd8, 32'd2, st1, r1, h1, s1);
      run_div(OP_DIVU, 32'd9, 32'd3, st2, r2, h2, s2);
      e = exp_q.pop_front();
      checks++;
      if (r1 !== e || st1 != 33) begin
         failures++;
         $display("FAIL b2b_first: result=%h stalls=%0d, required %h/33", r1, st1, e);
      end
      e = exp_q.pop_front();
      checks++;
      if (r2 !== e || st2 != 33) begin
         failures++;
         $display("FAIL b2b_second: result=%h stalls=%0d, required %h/33", r2, st2, e);
      end
   endtask

   initial begin
      test_reset();
      test_mul();
      test_fast_path();
      test_div();
      test_random_div();
      test_flush();
      test_async_reset();
      test_back_to_back();
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_empty: %0d entries left, required 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
